// File: rtl/dfr_pkg.sv
// dfr_pkg
// Shared types and constants for the DFR memory subsystem.
//   arb_state_t : arbiter FSM states (core priority / forced host slot)
//   owner_t     : tag carried with an outstanding read to route its data back
//   MEM_SEL_*   : host mem_sel region codes; one arbiter instance per region RAM
package dfr_pkg;

  typedef enum logic {ARB_CORE_PRI, ARB_HOST_FORCE} arb_state_t;

  typedef enum logic {OWNER_CORE, OWNER_HOST} owner_t;

  localparam int MEM_SEL_WIDTH = 3;

  localparam logic [MEM_SEL_WIDTH-1:0] MEM_SEL_INPUT   = 3'd1;
  localparam logic [MEM_SEL_WIDTH-1:0] MEM_SEL_RES_HIST = 3'd2;
  localparam logic [MEM_SEL_WIDTH-1:0] MEM_SEL_OUT_WGT = 3'd3;
  localparam logic [MEM_SEL_WIDTH-1:0] MEM_SEL_DFR_OUT = 3'd4;

endpackage

// File: rtl/dfr_mem_arbiter.sv
// dfr_mem_arbiter
// Shares one single-port, 1-cycle-latency DFR RAM between the host (AXI
// config path) and the core (controller / counters / matrix multiplier).
// The core has priority; the host is forced through after HOST_MAX_WAIT
// consecutive denied cycles. Read data is routed back to whichever
// requester issued the read.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   host_req/wen/addr/din         host request (held until host_gnt)
//   host_gnt/rvalid/rdata         host grant, read-return valid and data
//   core_req/wen/addr/din         core request (held until core_gnt)
//   core_gnt/rvalid/rdata         core grant, read-return valid and data
//   ram_wen/addr/din              RAM command, driven from the granted port
//   ram_dout                      RAM read data, one cycle after the address
module dfr_mem_arbiter
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_req,
  input  logic                  host_wen,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_din,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  core_req,
  input  logic                  core_wen,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CNT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(HOST_MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(HOST_MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             rd_pend_valid;
  owner_t           rd_pend_owner;
  logic             host_denied;

  // Grant decision. Everything is held at zero while rst is asserted so the
  // RAM sees no access in the reset cycle even though grants are combinational.
  always_comb begin
    host_gnt = 1'b0;
    core_gnt = 1'b0;
    if (!rst) begin
      if (state == ARB_HOST_FORCE) begin
        host_gnt = host_req;
      end else begin
        core_gnt = core_req;
        host_gnt = host_req && !core_req;
      end
    end
  end

  assign host_denied = host_req && !host_gnt;

  // RAM command mux. With no grant the core address/data are presented so the
  // RAM inputs do not toggle with host traffic, but the write enable stays low.
  always_comb begin
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      if (host_gnt) begin
        ram_wen  = host_wen;
        ram_addr = host_addr;
        ram_din  = host_din;
      end else begin
        ram_wen  = core_gnt && core_wen;
        ram_addr = core_addr;
        ram_din  = core_din;
      end
    end
  end

  // Arbiter FSM and host starvation counter. The forced host slot lasts one
  // cycle only, so the core loses at most one cycle per HOST_MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_CORE_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        ARB_CORE_PRI: begin
          if (host_denied && (wait_cnt == WAIT_LAST)) begin
            state <= ARB_HOST_FORCE;
          end
        end
        default: state <= ARB_CORE_PRI;
      endcase

      if (host_denied) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + CNT_ONE;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Outstanding-read tag: remembers who issued the read so the RAM data,
  // which arrives one cycle later, goes back to the right requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_valid <= 1'b0;
      rd_pend_owner <= OWNER_CORE;
    end else begin
      rd_pend_valid <= (host_gnt && !host_wen) || (core_gnt && !core_wen);
      rd_pend_owner <= host_gnt ? OWNER_HOST : OWNER_CORE;
    end
  end

  // A read tagged just before reset must not surface during the reset cycle.
  assign host_rvalid = !rst && rd_pend_valid && (rd_pend_owner == OWNER_HOST);
  assign core_rvalid = !rst && rd_pend_valid && (rd_pend_owner == OWNER_CORE);
  assign host_rdata  = host_rvalid ? ram_dout : '0;
  assign core_rdata  = core_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// tb_dfr_mem_arbiter
// Directed bench for dfr_mem_arbiter with a behavioural synchronous RAM
// (read-before-write, 1-cycle latency). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge of the same cycle.
module tb_dfr_mem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_wen;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_din;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          core_req, core_wen;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_din;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int compare_count  = 0;
  int mismatch_count = 0;

  always #5 clk = ~clk;

  dfr_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .HOST_MAX_WAIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_req(host_req),
    .host_wen(host_wen),
    .host_addr(host_addr),
    .host_din(host_din),
    .host_gnt(host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .core_req(core_req),
    .core_wen(core_wen),
    .core_addr(core_addr),
    .core_din(core_din),
    .core_gnt(core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ram_wen(ram_wen),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM, preloaded with 0x5A00_0000 | address.
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = 32'h5A00_0000 | i;
    end
  end

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_wen) mem[ram_addr] <= ram_din;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, then returns at
  // the falling edge so the caller can sample outputs for that cycle.
  task automatic applyStimulus(input logic r,
                               input logic h_req, input logic h_wen,
                               input logic [AW-1:0] h_addr, input logic [DW-1:0] h_din,
                               input logic c_req, input logic c_wen,
                               input logic [AW-1:0] c_addr, input logic [DW-1:0] c_din);
    @(posedge clk);
    #1;
    rst       = r;
    host_req  = h_req;
    host_wen  = h_wen;
    host_addr = h_addr;
    host_din  = h_din;
    core_req  = c_req;
    core_wen  = c_wen;
    core_addr = c_addr;
    core_din  = c_din;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    host_req = 1'b0; host_wen = 1'b0; host_addr = '0; host_din = '0;
    core_req = 1'b0; core_wen = 1'b0; core_addr = '0; core_din = '0;

    // Reset state: requests present during reset must produce nothing.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 14'h0010, 32'h1111_1111, 1'b1, 1'b0, 14'h0007, 32'h9);
    checkOutput("rst_host_gnt", host_gnt, 0);
    checkOutput("rst_core_gnt", core_gnt, 0);
    checkOutput("rst_ram_wen", ram_wen, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_din", ram_din, 0);
    checkOutput("rst_rvalids", {host_rvalid, core_rvalid}, 0);

    // Host only: write then read back 0xDEADBEEF at 0x0010.
    applyStimulus(1'b0, 1'b1, 1'b1, 14'h0010, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
    checkOutput("hw_gnt", host_gnt, 1);
    checkOutput("hw_core_gnt", core_gnt, 0);
    checkOutput("hw_ram_wen", ram_wen, 1);
    checkOutput("hw_ram_addr", ram_addr, 14'h0010);
    checkOutput("hw_ram_din", ram_din, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("hr_gnt", host_gnt, 1);
    checkOutput("hr_ram_wen", ram_wen, 0);
    checkOutput("hw_no_rvalid", host_rvalid, 0);
    idleCycle();
    checkOutput("hr_rvalid", host_rvalid, 1);
    checkOutput("hr_rdata", host_rdata, 32'hDEAD_BEEF);
    checkOutput("hr_core_rvalid", core_rvalid, 0);

    // Core only: 16 back-to-back reads of addresses 0..15.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      else        idleCycle();
      if (i < 16) checkOutput($sformatf("cr_gnt_%0d", i), core_gnt, 1);
      if (i > 0) begin
        checkOutput($sformatf("cr_rvalid_%0d", i - 1), core_rvalid, 1);
        checkOutput($sformatf("cr_rdata_%0d", i - 1), core_rdata, 32'h5A00_0000 | (i - 1));
      end
      checkOutput($sformatf("cr_host_rvalid_%0d", i), host_rvalid, 0);
    end
    idleCycle();
    checkOutput("cr_rvalid_end", core_rvalid, 0);

    // Contention: core reads 0x20 continuously, host read of 0x30 from t0.
    for (int k = 0; k <= 9; k++) begin
      applyStimulus(1'b0, (k <= 8), 1'b0, 14'h0030, '0, 1'b1, 1'b0, 14'h0020, '0);
      checkOutput($sformatf("ct_host_gnt_t%0d", k), host_gnt, (k == 8));
      checkOutput($sformatf("ct_core_gnt_t%0d", k), core_gnt, (k != 8));
      if (k == 8) begin
        checkOutput("ct_ram_addr_force", ram_addr, 14'h0030);
        checkOutput("ct_core_rdata_t8", core_rdata, 32'h5A00_0020);
      end
      if (k == 9) begin
        checkOutput("ct_host_rvalid_t9", host_rvalid, 1);
        checkOutput("ct_host_rdata_t9", host_rdata, 32'h5A00_0030);
        checkOutput("ct_core_rvalid_t9", core_rvalid, 0);
      end
    end
    idleCycle();

    // Same-cycle core read and host write at 0x0005: core reads the old value.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'h0005, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 14'h0005, 32'h2, 1'b1, 1'b0, 14'h0005, '0);
    checkOutput("sc_core_gnt", core_gnt, 1);
    checkOutput("sc_host_gnt", host_gnt, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 14'h0005, 32'h2, 1'b0, 1'b0, '0, '0);
    checkOutput("sc_host_gnt_late", host_gnt, 1);
    checkOutput("sc_core_rvalid", core_rvalid, 1);
    checkOutput("sc_core_rdata", core_rdata, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0005, '0, 1'b0, 1'b0, '0, '0);
    idleCycle();
    checkOutput("sc_host_rvalid", host_rvalid, 1);
    checkOutput("sc_host_rdata", host_rdata, 32'h2);

    // Reset the cycle after a core read grant: that read never returns.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0003, '0);
    checkOutput("mr_core_gnt", core_gnt, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b1, 14'h0033, 32'h77);
    checkOutput("mr_core_rvalid", core_rvalid, 0);
    checkOutput("mr_core_rdata", core_rdata, 0);
    checkOutput("mr_grants", {host_gnt, core_gnt}, 0);
    checkOutput("mr_ram_cmd", {ram_wen, ram_addr, ram_din}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("mr_host_gnt_after", host_gnt, 1);
    checkOutput("mr_core_rvalid_after", core_rvalid, 0);
    idleCycle();
    checkOutput("mr_host_rdata", host_rdata, 32'hDEAD_BEEF);

    // Host drops after 5 denied cycles; the forced grant restarts from re-raise.
    for (int k = 0; k <= 5; k++) begin
      applyStimulus(1'b0, (k < 5), 1'b0, 14'h0040, '0, 1'b1, 1'b0, 14'h0001, '0);
      checkOutput($sformatf("dr_host_gnt_pre%0d", k), host_gnt, 0);
    end
    for (int j = 0; j <= 9; j++) begin
      applyStimulus(1'b0, (j <= 8), 1'b0, 14'h0040, '0, 1'b1, 1'b0, 14'h0001, '0);
      checkOutput($sformatf("dr_host_gnt_r%0d", j), host_gnt, (j == 8));
      checkOutput($sformatf("dr_core_gnt_r%0d", j), core_gnt, (j != 8));
    end
    checkOutput("dr_host_rdata", host_rdata, 32'h5A00_0040);
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
